prog_ctr_seq: RTL

Parametrised program counter for the fetch stage, successor to the basic absolute-jump counter. It adds PC-relative branches, a stall hold, and subroutine call/return through an internal return-address stack (RAS). The block drives the instruction-memory address and takes its control inputs from the decoder and branch logic.

---
 rtl/prog_ctr_seq_pkg.sv | 18 +
 rtl/prog_ctr_seq_ret_stack.sv | 56 +++++
 rtl/prog_ctr_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/prog_ctr_seq_pkg.sv
// Shared definitions for the fetch-stage program counter: operation encoding and default sizes.
// Used by prog_ctr_seq and ret_stack.
package pc_pkg;

    localparam int D_DEF         = 10;
    localparam int OW_DEF        = 8;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_RET,
        OP_CALL,
        OP_JUMP,
        OP_BRANCH,
        OP_SEQ
    } pc_op_t;

endpackage

// File: rtl/prog_ctr_seq_ret_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// Overflow/underflow are same-cycle pulses for the caller's sticky error flag.
module ret_stack
    import pc_pkg::*;
#(
    parameter int D         = D_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         overflow,
    output logic         underflow
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [D-1:0]  mem [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_m1;
    logic [CW-1:0] count;

    // ptr addresses the next free slot; when full it also addresses the oldest entry
    assign ptr_m1    = ptr - PW'(1);
    assign top       = mem[ptr_m1];
    assign empty     = (count == '0);
    assign full      = (count == CW'(RAS_DEPTH));
    assign overflow  = push && full;
    assign underflow = pop && empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full)
                count <= count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr_m1;
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= push_data;
    end

endmodule

// File: rtl/prog_ctr_seq.sv
// Fetch-stage program counter with relative branch, stall and call/return.
// Define PC_RAS_EN to build the return-address stack; without it call acts as a jump and ret as an error.
module prog_ctr_seq
    import pc_pkg::*;
#(
    parameter int D         = D_DEF,
    parameter int OW        = OW_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          absjump_en,
    input  logic [D-1:0]  target,
    input  logic          branch_en,
    input  logic [OW-1:0] offset,
    input  logic          call_en,
    input  logic          ret_en,
    input  logic          err_clr,
    output logic [D-1:0]  prog_ctr,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_err
);

    pc_op_t       op;
    logic [D-1:0] pc_inc;
    logic [D-1:0] off_ext;
    logic [D-1:0] next_pc;
    logic         err_event;

    assign pc_inc  = prog_ctr + D'(1);
    assign off_ext = D'($signed(offset));

    always_comb begin
        op = OP_SEQ;
        if (stall)           op = OP_HOLD;
        else if (ret_en)     op = OP_RET;
        else if (call_en)    op = OP_CALL;
        else if (absjump_en) op = OP_JUMP;
        else if (branch_en)  op = OP_BRANCH;
    end

`ifdef PC_RAS_EN
    logic [D-1:0] stk_top;
    logic         stk_empty;
    logic         stk_full;
    logic         stk_overflow;
    logic         stk_underflow;

    ret_stack #(.D(D), .RAS_DEPTH(RAS_DEPTH)) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (op == OP_CALL),
        .pop       (op == OP_RET),
        .push_data (pc_inc),
        .top       (stk_top),
        .empty     (stk_empty),
        .full      (stk_full),
        .overflow  (stk_overflow),
        .underflow (stk_underflow)
    );

    assign err_event = stk_overflow || stk_underflow;
    assign ras_empty = stk_empty;
    assign ras_full  = stk_full;
`else
    assign err_event = (op == OP_RET);
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
`endif

    always_comb begin
        next_pc = prog_ctr;
        case (op)
            OP_HOLD:   next_pc = prog_ctr;
`ifdef PC_RAS_EN
            OP_RET:    next_pc = stk_empty ? pc_inc : stk_top;
`else
            OP_RET:    next_pc = pc_inc;
`endif
            OP_CALL:   next_pc = target;
            OP_JUMP:   next_pc = target;
            OP_BRANCH: next_pc = prog_ctr + off_ext;
            default:   next_pc = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prog_ctr <= '0;
        else
            prog_ctr <= next_pc;
    end

    // a new error in the same cycle as err_clr leaves the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ras_err <= 1'b0;
        else if (err_event)
            ras_err <= 1'b1;
        else if (err_clr)
            ras_err <= 1'b0;
    end

endmodule
